// File: rtl/tube_scheduler.sv
// -----------------------------------------------------------------------------
// tube_scheduler
//
// Purpose: position and gap generator for three scrolling tubes. A round
// begins with start. Each frame_tick while running scrolls every tube left by
// the current step. A tube that would run past column 0 respawns behind the
// last tube, keeping the exact pitch, and gets a new pseudo-random gap. A pulse
// is raised when a tube's right edge crosses the bird column. halt freezes
// the tubes until the next start.
//
// Optional feature: define TUBE_SPEEDUP_EN to add a 3-bit pass counter. Every
// 8 passes the step grows by 1, up to 8. Without the macro the step is fixed
// at SPEED.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   frame_tick  in   one-cycle pulse per frame
//   start       in   one-cycle pulse, begin/restart a round
//   halt        in   level, collision: freeze tubes
//   tube_x[i]   out  11-bit left edge of tube i (>= 1024 is off-screen)
//   gap_y[i]    out  11-bit top row of tube i's 250-pixel gap
//   pass_pulse  out  one-cycle pulse when a tube right edge crosses column 180
//   running     out  high while in RUN
// -----------------------------------------------------------------------------
module tube_scheduler #(
  parameter int          SPEED     = 4,
  parameter int          SPACING   = 400,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        halt,
  output logic [10:0] tube_x [2:0],
  output logic [10:0] gap_y  [2:0],
  output logic        pass_pulse,
  output logic        running
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [10:0] x_q   [3];
  logic [10:0] x_d   [3];
  logic [10:0] gap_q [3];
  logic [10:0] gap_d [3];
  logic [10:0] gap_new [3];
  logic        pass_q, pass_d;
  logic        running_q, running_d;
  logic        load, move;
  logic [3:0]  step;

  // Fold a 9-bit random value into 60..443 so that the 250-pixel gap always
  // fits on screen.
  function automatic logic [10:0] gap_of(input logic [8:0] r);
    if (r < 9'd384) return 11'd60 + {2'b00, r};
    else            return 11'd60 + {2'b00, r} - 11'd256;
  endfunction

  // Each tube draws from its own LFSR slice. This keeps several tubes that
  // load in the same cycle from getting identical gaps.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_gap
      localparam int OFF = (gi == 0) ? 0 : (gi == 1) ? 4 : 7;
      assign gap_new[gi] = gap_of(lfsr_q[OFF +: 9]);
    end
  endgenerate

`ifdef TUBE_SPEEDUP_EN
  logic [3:0] speed_q, speed_d;
  logic [2:0] cnt_q, cnt_d;
  assign step = speed_q;
`else
  assign step = 4'(SPEED);
`endif

  always_comb begin
    state_d = state_q;
    // Fibonacci LFSR, taps 16,14,13,11. It runs freely in every state.
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    x_d     = x_q;
    gap_d   = gap_q;
    pass_d  = 1'b0;
    load    = 1'b0;
    move    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        // halt takes priority over both start and frame_tick
        if (halt)            state_d = FROZEN;
        else if (frame_tick) move    = 1'b1;
      end
      FROZEN: begin
        if (start) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    for (int i = 0; i < 3; i++) begin
      if (load) begin
        x_d[i]   = 11'(1024 + i * SPACING);
        gap_d[i] = gap_new[i];
      end else if (move) begin
        if (x_q[i] >= {7'd0, step}) begin
          x_d[i] = x_q[i] - {7'd0, step};
          // The right edge (x + 120) crosses column 180 exactly when x goes
          // from above 60 to 60 or below.
          if ((x_q[i] > 11'd60) && (x_d[i] <= 11'd60)) pass_d = 1'b1;
        end else begin
          x_d[i]   = x_q[i] + 11'(3 * SPACING) - {7'd0, step};
          gap_d[i] = gap_new[i];
        end
      end
    end

    running_d = (state_d == RUN);
  end

`ifdef TUBE_SPEEDUP_EN
  always_comb begin
    speed_d = speed_q;
    cnt_d   = cnt_q;
    if (load) begin
      speed_d = 4'(SPEED);
      cnt_d   = 3'd0;
    end else if (pass_d) begin
      cnt_d = cnt_q + 3'd1;
      // Counter wrap marks every eighth pass.
      if ((cnt_q == 3'd7) && (speed_q < 4'd8)) speed_d = speed_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      speed_q <= 4'(SPEED);
      cnt_q   <= 3'd0;
    end else begin
      speed_q <= speed_d;
      cnt_q   <= cnt_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      lfsr_q    <= LFSR_SEED;
      pass_q    <= 1'b0;
      running_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        x_q[i]   <= 11'h7FF;
        gap_q[i] <= 11'd200;
      end
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      pass_q    <= pass_d;
      running_q <= running_d;
      for (int i = 0; i < 3; i++) begin
        x_q[i]   <= x_d[i];
        gap_q[i] <= gap_d[i];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_out
      assign tube_x[gi] = x_q[gi];
      assign gap_y[gi]  = gap_q[gi];
    end
  endgenerate

  assign pass_pulse = pass_q;
  assign running    = running_q;

endmodule

// File: tb/tb_tube_scheduler.sv
module tb_tube_scheduler;
  localparam int SPEED   = 4;
  localparam int SPACING = 400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic [10:0] tube_x [2:0];
  logic [10:0] gap_y  [2:0];
  logic        pass_pulse;
  logic        running;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tube_scheduler #(.SPEED(SPEED), .SPACING(SPACING), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .halt(halt),
    .tube_x(tube_x), .gap_y(gap_y), .pass_pulse(pass_pulse), .running(running)
  );

  // ---------------- reference model (game rules, integer arithmetic) -------
  int m_state;  // 0 idle, 1 run, 2 frozen
  int m_x[3];
  int m_gap[3];
  int m_lfsr, m_speed, m_cnt;
  bit m_pass;

  function automatic int gap_from(int r);
    if (r < 384) return 60 + r;
    return 60 + r - 256;
  endfunction

  function automatic int slice_of(int lfsr, int i);
    int off;
    off = (i == 0) ? 0 : (i == 1) ? 4 : 7;
    return (lfsr >> off) & 511;
  endfunction

  task automatic model_reset();
    m_state = 0; m_lfsr = 'hACE1; m_pass = 0; m_speed = SPEED; m_cnt = 0;
    for (int i = 0; i < 3; i++) begin m_x[i] = 2047; m_gap[i] = 200; end
  endtask

  task automatic model_load();
    for (int i = 0; i < 3; i++) begin
      m_x[i]   = 1024 + i * SPACING;
      m_gap[i] = gap_from(slice_of(m_lfsr, i));
    end
    m_speed = SPEED; m_cnt = 0; m_state = 1;
  endtask

  task automatic model_step();
    int nx, fb;
    m_pass = 0;
    if (m_state == 0 || m_state == 2) begin
      if (start) model_load();
    end else begin
      if (halt) m_state = 2;
      else if (frame_tick) begin
        for (int i = 0; i < 3; i++) begin
          if (m_x[i] >= m_speed) begin
            nx = m_x[i] - m_speed;
            if (m_x[i] + 120 > 180 && nx + 120 <= 180) m_pass = 1;
            m_x[i] = nx;
          end else begin
            m_x[i]   = m_x[i] + 3 * SPACING - m_speed;
            m_gap[i] = gap_from(slice_of(m_lfsr, i));
          end
        end
`ifdef TUBE_SPEEDUP_EN
        if (m_pass) begin
          m_cnt = (m_cnt + 1) % 8;
          if (m_cnt == 0 && m_speed < 8) m_speed = m_speed + 1;
        end
`endif
      end
    end
    fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
    m_lfsr = ((m_lfsr << 1) | fb) & 'hFFFF;
  endtask

  // one clock: model follows the inputs sampled at the edge; sample #1 after
  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (tube_x[i] !== 11'h7FF) begin fails++; $display("FAIL reset_tube_x[%0d] got %0d want 2047", i, tube_x[i]); end
      tests++;
      if (gap_y[i] !== 11'd200) begin fails++; $display("FAIL reset_gap_y[%0d] got %0d want 200", i, gap_y[i]); end
    end
    tests++;
    if (running !== 1'b0 || pass_pulse !== 1'b0) begin
      fails++; $display("FAIL reset_flags got running=%b pass=%b want 0 0", running, pass_pulse);
    end
  endtask

  task automatic test_start();
    int exp_x[3];
    exp_x = '{1024, 1424, 1824};
    start = 1'b1; cyc(); start = 1'b0;
    tests++;
    if (running !== 1'b1) begin fails++; $display("FAIL start_running got %b want 1", running); end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (tube_x[i] !== 11'(exp_x[i])) begin fails++; $display("FAIL start_tube_x[%0d] got %0d want %0d", i, tube_x[i], exp_x[i]); end
      tests++;
      if (gap_y[i] < 11'd60 || gap_y[i] > 11'd443 || gap_y[i] !== 11'(m_gap[i])) begin
        fails++; $display("FAIL start_gap_y[%0d] got %0d want %0d (60..443)", i, gap_y[i], m_gap[i]);
      end
    end
  endtask

  task automatic test_scroll();
    logic [10:0] prev;
    for (int k = 0; k < 10; k++) begin
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
      prev = tube_x[0];
      cyc(); cyc();
      tests++;
      if (tube_x[0] !== prev) begin fails++; $display("FAIL scroll_hold got %0d want %0d", tube_x[0], prev); end
    end
    tests++;
    if (tube_x[0] !== 11'd984) begin fails++; $display("FAIL scroll_10_ticks got %0d want 984", tube_x[0]); end
  endtask

  task automatic test_pass();
    bit found = 0;
    for (int k = 0; k < 400 && !found; k++) begin
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
      tests++;
      if (pass_pulse !== m_pass) begin fails++; $display("FAIL pass_vs_model x0=%0d got %b want %b", tube_x[0], pass_pulse, m_pass); end
      if (tube_x[0] == 11'd60) begin
        found = 1;
        tests++;
        if (pass_pulse !== 1'b1) begin fails++; $display("FAIL pass_at_60 got %b want 1", pass_pulse); end
      end
      cyc();
      tests++;
      if (pass_pulse !== 1'b0) begin fails++; $display("FAIL pass_one_cycle got %b want 0", pass_pulse); end
    end
    tests++;
    if (!found) begin fails++; $display("FAIL pass_reach_60 got x0=%0d want 60 within bound", tube_x[0]); end
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
    tests++;
    if (pass_pulse !== 1'b0) begin fails++; $display("FAIL pass_next_tick got %b want 0 (x0=%0d)", pass_pulse, tube_x[0]); end
    cyc();
  endtask

  task automatic test_respawn();
    int old_x, spd;
    bit done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      old_x = tube_x[0]; spd = m_speed;
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
      if (old_x < spd) begin
        done = 1;
        tests++;
        if (tube_x[0] !== 11'(old_x + 3 * SPACING - spd)) begin
          fails++; $display("FAIL respawn_x got %0d want %0d", tube_x[0], old_x + 3 * SPACING - spd);
        end
        tests++;
        if (gap_y[0] < 11'd60 || gap_y[0] > 11'd443 || gap_y[0] !== 11'(m_gap[0])) begin
          fails++; $display("FAIL respawn_gap got %0d want %0d", gap_y[0], m_gap[0]);
        end
        tests++;
        if (pass_pulse !== 1'b0) begin fails++; $display("FAIL respawn_no_pass got %b want 0", pass_pulse); end
      end
      cyc();
    end
    tests++;
    if (!done) begin fails++; $display("FAIL respawn_reached got x0=%0d want a respawn within bound", tube_x[0]); end
  endtask

  task automatic test_halt();
    logic [10:0] saved [3];
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc();
    for (int i = 0; i < 3; i++) saved[i] = tube_x[i];
    halt = 1'b1; frame_tick = 1'b1; cyc(); halt = 1'b0; frame_tick = 1'b0;
    tests++;
    if (running !== 1'b0) begin fails++; $display("FAIL halt_running got %b want 0", running); end
    for (int k = 0; k < 3; k++) begin frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc(); end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (tube_x[i] !== saved[i]) begin fails++; $display("FAIL halt_frozen_x[%0d] got %0d want %0d", i, tube_x[i], saved[i]); end
    end
    start = 1'b1; cyc(); start = 1'b0;
    tests++;
    if (running !== 1'b1 || tube_x[0] !== 11'd1024 || tube_x[1] !== 11'd1424 || tube_x[2] !== 11'd1824) begin
      fails++; $display("FAIL halt_restart got run=%b x=%0d,%0d,%0d want 1 1024,1424,1824",
                        running, tube_x[0], tube_x[1], tube_x[2]);
    end
  endtask

  task automatic test_start_in_run();
    for (int k = 0; k < 3; k++) begin frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc(); end
    start = 1'b1; cyc(); start = 1'b0;
    tests++;
    if (tube_x[0] !== 11'd1012 || running !== 1'b1) begin
      fails++; $display("FAIL start_in_run got x0=%0d run=%b want 1012 1", tube_x[0], running);
    end
    // halt and start together: halt wins
    halt = 1'b1; start = 1'b1; cyc(); halt = 1'b0; start = 1'b0;
    tests++;
    if (running !== 1'b0 || tube_x[0] !== 11'd1012) begin
      fails++; $display("FAIL halt_beats_start got run=%b x0=%0d want 0 1012", running, tube_x[0]);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 6000; k++) begin
      frame_tick = ($urandom_range(0, 1) == 0);
      halt       = ($urandom_range(0, 59) == 0);
      start      = ($urandom_range(0, 29) == 0);
      cyc();
      frame_tick = 1'b0; halt = 1'b0; start = 1'b0;
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (tube_x[i] !== 11'(m_x[i]) || gap_y[i] !== 11'(m_gap[i])) begin
          fails++; $display("FAIL random_tube[%0d] cyc %0d got x=%0d gap=%0d want x=%0d gap=%0d",
                            i, k, tube_x[i], gap_y[i], m_x[i], m_gap[i]);
        end
      end
      tests++;
      if (pass_pulse !== m_pass || running !== (m_state == 1)) begin
        fails++; $display("FAIL random_flags cyc %0d got pass=%b run=%b want pass=%b run=%b",
                          k, pass_pulse, running, m_pass, (m_state == 1));
      end
    end
  endtask

  task automatic test_reset_mid();
    if (!running) begin start = 1'b1; cyc(); start = 1'b0; end
    for (int k = 0; k < 5; k++) begin frame_tick = 1'b1; cyc(); frame_tick = 1'b0; end
    #2 rst = 1'b1;
    #1;
    model_reset();
    tests++;
    if (tube_x[0] !== 11'h7FF || gap_y[0] !== 11'd200 || running !== 1'b0 || pass_pulse !== 1'b0) begin
      fails++; $display("FAIL reset_mid got x0=%0d gap0=%0d run=%b pass=%b want 2047 200 0 0",
                        tube_x[0], gap_y[0], running, pass_pulse);
    end
    cyc(); rst = 1'b0;
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
    tests++;
    if (tube_x[0] !== 11'h7FF || running !== 1'b0) begin
      fails++; $display("FAIL idle_ignores_tick got x0=%0d run=%b want 2047 0", tube_x[0], running);
    end
  endtask

`ifdef TUBE_SPEEDUP_EN
  task automatic test_speedup();
    int passes, before[3], want;
    int targets[2];
    targets = '{8, 40};
    start = 1'b1; cyc(); start = 1'b0;
    passes = 0;
    for (int t = 0; t < 2; t++) begin
      for (int k = 0; k < 8000 && passes < targets[t]; k++) begin
        frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
        if (pass_pulse) passes++;
      end
      tests++;
      if (passes < targets[t]) begin fails++; $display("FAIL speedup_passes got %0d want %0d", passes, targets[t]); end
      for (int i = 0; i < 3; i++) before[i] = tube_x[i];
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
      if (pass_pulse) passes++;
      want = (t == 0) ? 5 : 8;
      for (int i = 0; i < 3; i++) begin
        if (before[i] >= 16 && before[i] < 2000) begin
          tests++;
          if (before[i] - int'(tube_x[i]) != want) begin
            fails++; $display("FAIL speedup_step[%0d] got %0d want %0d", i, before[i] - int'(tube_x[i]), want);
          end
        end
      end
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_start();
    test_scroll();
    test_pass();
    test_respawn();
    test_halt();
    test_start_in_run();
    test_random();
    test_reset_mid();
`ifdef TUBE_SPEEDUP_EN
    test_speedup();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
